// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with clock enable,
// hold / shift right / shift left / parallel load modes, and a built-in
// auto-serialiser that shifts a loaded word out LSB-first on sout_r.
// Optional feature macro: ROTATE_EN (adds input rot; mode 01/10 rotate
// instead of shifting in ser_in_* while in IDLE).
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic             start,
`ifdef ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             busy_nxt, done_nxt;

    // Serial taps come straight from the register ends.
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Next-state and datapath selection; en=0 leaves every register unchanged.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = done;
        if (en) begin
            done_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_nxt     = d;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b1;
                        state_nxt = SERIAL;
                    end else begin
                        case (mode)
                            2'b00: q_nxt = q;
`ifdef ROTATE_EN
                            2'b01: q_nxt = rot ? {q[0], q[WIDTH-1:1]}
                                               : {ser_in_msb, q[WIDTH-1:1]};
                            2'b10: q_nxt = rot ? {q[WIDTH-2:0], q[WIDTH-1]}
                                               : {q[WIDTH-2:0], ser_in_lsb};
`else
                            2'b01: q_nxt = {ser_in_msb, q[WIDTH-1:1]};
                            2'b10: q_nxt = {q[WIDTH-2:0], ser_in_lsb};
`endif
                            2'b11: q_nxt = d;
                        endcase
                    end
                end
                SERIAL: begin
                    q_nxt = {1'b0, q[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RESET_VAL;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
        end else begin
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Rotate checks are compiled in only when ROTATE_EN is defined.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       ser_in_msb;
    logic       ser_in_lsb;
    logic       start;
`ifdef ROTATE_EN
    logic       rot;
`endif
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;

    int nerr;
    int nchk;
    int busy_cycles;

    univ_shift_reg #(
        .WIDTH(8),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .d(d),
        .ser_in_msb(ser_in_msb),
        .ser_in_lsb(ser_in_lsb),
        .start(start),
`ifdef ROTATE_EN
        .rot(rot),
`endif
        .q(q),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] bits_b4;
        logic [7:0] bits_0f;
        logic [7:0] bits_f0;
        nerr = 0;
        nchk = 0;
        // Hand-written LSB-first bit sequences, index = busy cycle number.
        bits_b4 = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // 0,0,1,0,1,1,0,1
        bits_0f = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}; // 1,1,1,1,0,0,0,0
        bits_f0 = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // 0,0,0,0,1,1,1,1

        rst = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0; start = 1'b0;
`ifdef ROTATE_EN
        rot = 1'b0;
`endif
        #2;

        // Reset
        tick();
        chk("reset_q", q, 8'hA5);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        chk("reset_sout_r", {7'd0, sout_r}, 8'd1);
        chk("reset_sout_l", {7'd0, sout_l}, 8'd1);

        // Modes
        rst = 1'b0; en = 1'b1; mode = 2'b11; d = 8'h81;
        tick();
        chk("load_81", q, 8'h81);
        mode = 2'b01; ser_in_msb = 1'b1;
        tick();
        chk("shr_msb1", q, 8'hC0);
        mode = 2'b10; ser_in_lsb = 1'b0;
        tick();
        chk("shl_lsb0", q, 8'h80);
        mode = 2'b00;
        repeat (3) tick();
        chk("hold3", q, 8'h80);
        en = 1'b0; mode = 2'b11; d = 8'hFF;
        tick();
        chk("en0_load", q, 8'h80);
        chk("en0_sout_l", {7'd0, sout_l}, 8'd1);
        chk("en0_sout_r", {7'd0, sout_r}, 8'd0);

        // Serialise 8'hB4
        en = 1'b1; mode = 2'b00; d = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser_busy_%0d", i), {7'd0, busy}, 8'd1);
            chk($sformatf("ser_bit_%0d", i), {7'd0, sout_r}, {7'd0, bits_b4[i]});
            chk($sformatf("ser_nodone_%0d", i), {7'd0, done}, 8'd0);
            tick();
        end
        chk("ser_done", {7'd0, done}, 8'd1);
        chk("ser_busy_end", {7'd0, busy}, 8'd0);
        chk("ser_q_end", q, 8'h00);
        tick();
        chk("ser_done_clr", {7'd0, done}, 8'd0);

        // Stall for two cycles after bit 3 appears
        d = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cycles++;
            chk($sformatf("stall_bit_%0d", i), {7'd0, sout_r}, {7'd0, bits_b4[i]});
            if (i == 3) begin
                en = 1'b0;
                repeat (2) begin
                    tick();
                    if (busy === 1'b1) busy_cycles++;
                    chk("stall_hold_bit3", {7'd0, sout_r}, {7'd0, bits_b4[3]});
                    chk("stall_nodone", {7'd0, done}, 8'd0);
                end
                en = 1'b1;
            end
            tick();
        end
        chk("stall_busy_len", busy_cycles[7:0], 8'd10);
        chk("stall_done", {7'd0, done}, 8'd1);
        en = 1'b0;
        tick();
        chk("done_held_en0", {7'd0, done}, 8'd1);
        en = 1'b1;
        tick();
        chk("done_clr_en1", {7'd0, done}, 8'd0);

        // Reset in the middle of SERIAL
        d = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("midrst_busy_pre", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_q", q, 8'hA5);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_done", {7'd0, done}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_done", {7'd0, done}, 8'd0);
        end
        chk("midrst_q_after", q, 8'hA5);

        // start beats mode in IDLE
        mode = 2'b01; ser_in_msb = 1'b1; d = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        chk("prio_q", q, 8'h3C);
        chk("prio_busy", {7'd0, busy}, 8'd1);
        repeat (8) tick();
        chk("prio_done", {7'd0, done}, 8'd1);
        mode = 2'b00;
        tick();

        // Back-to-back words with start held high
        d = 8'h0F; start = 1'b1;
        tick();
        d = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_w0_bit_%0d", i), {7'd0, sout_r}, {7'd0, bits_0f[i]});
            tick();
        end
        chk("b2b_done", {7'd0, done}, 8'd1);
        chk("b2b_gap_busy", {7'd0, busy}, 8'd0);
        tick();
        start = 1'b0;
        chk("b2b_w1_q", q, 8'hF0);
        chk("b2b_w1_busy", {7'd0, busy}, 8'd1);
        chk("b2b_w1_done_clr", {7'd0, done}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_w1_bit_%0d", i), {7'd0, sout_r}, {7'd0, bits_f0[i]});
            tick();
        end
        chk("b2b_w1_done", {7'd0, done}, 8'd1);
        tick();

`ifdef ROTATE_EN
        // Rotation ignores ser_in_*
        mode = 2'b11; d = 8'h81; rot = 1'b0;
        tick();
        chk("rot_load", q, 8'h81);
        rot = 1'b1; mode = 2'b01; ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
        tick();
        chk("rot_right", q, 8'hC0);
        mode = 2'b10;
        tick();
        chk("rot_left1", q, 8'h81);
        tick();
        chk("rot_left2", q, 8'h03);
        rot = 1'b0;
        tick();
        chk("rot_off_shl", q, 8'h06);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
